// File: rtl/sar_compare_search_if.sv
// Bus between the successive-approximation controller and its comparator/host.
// master = controller side, slave = comparator and start-request side.
interface sar_compare_search_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [2:0]       cm;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             exact;
  logic             err;

  modport master (
    input  start,
    input  cm,
    output trial,
    output busy,
    output done,
    output result,
    output exact,
    output err
  );

  modport slave (
    output start,
    output cm,
    input  trial,
    input  busy,
    input  done,
    input  result,
    input  exact,
    input  err
  );
endinterface

// File: rtl/sar_compare_search.sv
// Binary-search controller: drives a trial word into a combinational magnitude
// comparator and resolves the unknown B operand MSB first, exiting early on equality.
module sar_compare_search #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sar_compare_search_if.master bus
);

  localparam int IW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TEST = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] trial_q,  trial_d;
  logic [IW-1:0]    idx_q,    idx_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exact_q,  exact_d;
  logic             err_q,    err_d;
  logic [WIDTH-1:0] next_trial;

  always_comb begin
    state_d    = state_q;
    trial_d    = trial_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    exact_d    = exact_q;
    err_d      = err_q;
    next_trial = trial_q;

    case (state_q)
      S_IDLE: begin
        trial_d = '0;
        busy_d  = 1'b0;
        if (bus.start) begin
          trial_d[WIDTH-1] = 1'b1;
          idx_d    = IW'(WIDTH - 1);
          busy_d   = 1'b1;
          result_d = '0;
          exact_d  = 1'b0;
          err_d    = 1'b0;
          state_d  = S_TEST;
        end
      end

      S_TEST: begin
        case (bus.cm)
          3'b010: begin
            result_d = trial_q;
            exact_d  = 1'b1;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = S_FIN;
          end
          3'b100, 3'b001: begin
            // trial above B drops the bit under test; trial below B keeps it
            if (bus.cm == 3'b100) begin
              next_trial[idx_q] = 1'b0;
            end
            if (idx_q == '0) begin
              trial_d  = next_trial;
              result_d = next_trial;
              exact_d  = 1'b0;
              busy_d   = 1'b0;
              done_d   = 1'b1;
              state_d  = S_FIN;
            end else begin
              next_trial[idx_q - IW'(1)] = 1'b1;
              trial_d = next_trial;
              idx_d   = idx_q - IW'(1);
            end
          end
          default: begin
            err_d    = 1'b1;
            result_d = '0;
            exact_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = S_FIN;
          end
        endcase
      end

      S_FIN: begin
        trial_d = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        trial_d = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      trial_q  <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      exact_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      exact_q  <= exact_d;
      err_q    <= err_d;
    end
  end

  assign bus.trial  = trial_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.exact  = exact_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_sar_compare_search.sv
// Directed bench for sar_compare_search: a behavioural comparator answers each trial
// against a chosen B, and every search is checked against hand-computed trials/results.
module tb_sar_compare_search;

  logic       clk;
  logic       rst;
  logic [3:0] b_val;
  logic       force_en;
  logic [2:0] force_cm;
  int         n_checks;
  int         n_errors;

  sar_compare_search_if #(.WIDTH(4)) bus ();

  sar_compare_search #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cm = {A>B, A==B, A<B}, optionally overridden to inject an illegal code
  always_comb begin
    if (force_en) bus.cm = force_cm;
    else          bus.cm = {bus.trial > b_val, bus.trial == b_val, bus.trial < b_val};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Entered at the negedge after the start edge; runs to the IDLE cycle after done.
  task automatic follow(input string tag, input logic [15:0] exp_trials, input int exp_lat,
                        input logic [3:0] exp_res, input logic exp_exact);
    int n;
    logic [15:0] tr;
    tr = exp_trials;
    n  = 1;
    while (bus.done !== 1'b1 && n < 12) begin
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      if (n <= 4) check({tag, "_trial"}, 32'(bus.trial), 32'(tr[15-4*(n-1) -: 4]));
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_done"},    32'(bus.done), 32'd1);
    check({tag, "_busy_fin"}, 32'(bus.busy), 32'd0);
    check({tag, "_result"},  32'(bus.result), 32'(exp_res));
    check({tag, "_exact"},   32'(bus.exact), 32'(exp_exact));
    check({tag, "_err"},     32'(bus.err), 32'd0);
    $display("search %s B=%0d result=%0d exact=%0d err=%0d cycles=%0d",
             tag, b_val, bus.result, bus.exact, bus.err, n);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_trial_idle"}, 32'(bus.trial), 32'd0);
    check({tag, "_result_hold"}, 32'(bus.result), 32'(exp_res));
  endtask

  task automatic search(input string tag, input logic [3:0] b, input logic [15:0] exp_trials,
                        input int exp_lat, input logic [3:0] exp_res, input logic exp_exact);
    b_val     = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    follow(tag, exp_trials, exp_lat, exp_res, exp_exact);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    b_val     = 4'd0;
    force_en  = 1'b0;
    force_cm  = 3'b000;
    repeat (2) @(negedge clk);
    check("rst_trial",  32'(bus.trial), 32'd0);
    check("rst_busy",   32'(bus.busy), 32'd0);
    check("rst_done",   32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_exact",  32'(bus.exact), 32'd0);
    check("rst_err",    32'(bus.err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // reset during the 2nd TEST cycle aborts silently
    b_val     = 4'd9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("midrst_trial_before", 32'(bus.trial), 32'd12);
    rst = 1'b1;
    #1;
    check("midrst_trial", 32'(bus.trial), 32'd0);
    check("midrst_busy",  32'(bus.busy), 32'd0);
    check("midrst_done",  32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_done", 32'(bus.done), 32'd0);
      check("midrst_idle",    32'(bus.busy), 32'd0);
    end
    $display("reset mid-search B=9 aborted");
    search("b9",  4'd9,  16'h8CA9, 5, 4'd9,  1'b1);

    search("b6",  4'd6,  16'h8460, 4, 4'd6,  1'b1);
    search("b0",  4'd0,  16'h8421, 5, 4'd0,  1'b0);
    search("b15", 4'd15, 16'h8CEF, 5, 4'd15, 1'b1);

    // start held high across two searches
    b_val     = 4'd5;
    bus.start = 1'b1;
    @(negedge clk);
    follow("b5_held", 16'h8465, 5, 4'd5, 1'b1);
    check("held_busy_idle",   32'(bus.busy), 32'd0);
    check("held_result_keep", 32'(bus.result), 32'd5);
    check("held_exact_keep",  32'(bus.exact), 32'd1);
    b_val = 4'd10;
    @(negedge clk);
    check("held_accept_busy",  32'(bus.busy), 32'd1);
    check("held_accept_clear", 32'(bus.result), 32'd0);
    follow("b10_held", 16'h8CA0, 4, 4'd10, 1'b1);
    bus.start = 1'b0;
    @(negedge clk);

    // illegal cm on the 2nd TEST cycle
    b_val     = 4'd6;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("errcase_trial1", 32'(bus.trial), 32'd8);
    @(negedge clk);
    force_cm = 3'b011;
    force_en = 1'b1;
    @(negedge clk);
    force_en = 1'b0;
    check("errcase_done",   32'(bus.done), 32'd1);
    check("errcase_err",    32'(bus.err), 32'd1);
    check("errcase_result", 32'(bus.result), 32'd0);
    check("errcase_exact",  32'(bus.exact), 32'd0);
    check("errcase_busy",   32'(bus.busy), 32'd0);
    $display("search errcase cm=011 err=%0d result=%0d", bus.err, bus.result);
    @(negedge clk);
    check("errcase_err_hold", 32'(bus.err), 32'd1);
    search("b6_after_err", 4'd6, 16'h8460, 4, 4'd6, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sar_compare_search.md
Name: sar_compare_search

Overview:
- Successive-approximation search controller; the driving end of the 4-bit magnitude comparator interface.
- Presents a trial word on the comparator A input and consumes the comparator's 3-bit result CM.
- Resolves the unknown word on the comparator B input by binary search, MSB first, with early exit on equality.
- Sits beside a combinational comparator instance; used for threshold or code discovery in the datapath.

Parameters:
WIDTH, 4, width of trial/result words; must match comparator operand width (WIDTH >= 2).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a new search; sampled only in IDLE.
cm  input  3  comparator result for A=trial; cm[0]=A<B, cm[1]=A=B, cm[2]=A>B.
trial  output  WIDTH  registered word driven to comparator A input.
busy  output  1  high while a search is in progress.
done  output  1  one-cycle pulse when a search ends.
result  output  WIDTH  resolved B value; held until next start.
exact  output  1  equality was directly observed; held with result.
err  output  1  illegal cm code aborted the search; held with result.

Behaviour:
- Reset (async, rst=1): state=IDLE. trial, result, idx all 0. busy, done, exact and err are 0. Reset mid-search aborts with no done pulse.
- The comparator is combinational. cm is sampled on the same clock edge on which the current trial has been stable for one cycle.
- States are IDLE, TEST and FIN.
- IDLE:
  - trial=0, busy=0.
  - On start=1: trial<=1<<(WIDTH-1), idx<=WIDTH-1, busy<=1, and result, exact, err cleared to 0. Go to TEST.
- TEST (one cycle per bit), decided on cm:
  - cm=3'b010: result<=trial, exact<=1. Go to FIN (early exit).
  - cm=3'b100 (trial>B): clear trial[idx].
  - cm=3'b001 (trial<B): keep trial[idx].
  - Any other cm (000, 011, 101, 110, 111): err<=1, result<=0, exact<=0. Go to FIN.
- TEST continuation after a legal non-equal code:
  - If idx==0: result<=updated trial, exact<=0. Go to FIN.
  - Else: idx<=idx-1, set trial[idx-1]. Stay in TEST.
- FIN:
  - done=1 for exactly this cycle, busy=0, trial<=0. Go to IDLE.
  - result, exact and err persist until the next accepted start or reset.
- Latency: start edge to done is at most WIDTH+1 cycles, and fewer on an early equality exit.
- start while busy, or in FIN: ignored, no queueing.
- start held high continuously: a new search begins on the cycle after FIN.
- A final step with cm=100 yields an inferred result with exact=0. A final cm=001 is legal and yields result=trial (exact=0).
- cm is don't-care in IDLE and FIN.

Test Plan:
- Reset mid-search: B=9, start, assert rst at the 2nd TEST cycle -> all outputs 0, no done pulse; a following start with B=9 completes normally.
- B=6, start -> trial sequence 8,4,6 with cm 100,001,010. done in 4th cycle after start, result=6, exact=1, err=0.
- B=0, start -> trial sequence 8,4,2,1, all cm=100. done after 5 cycles, result=0, exact=0.
- B=15, start -> trial sequence 8,12,14,15, cm 001,001,001,010. result=15, exact=1.
- B=5 then B=10 back-to-back with start held high -> first result=5 exact=1, second result=10 exact=1. No start accepted while busy; result for B=5 held until the second start is accepted.
- Force cm=3'b011 during the 2nd TEST cycle -> done pulse next cycle, err=1, result=0, exact=0. A subsequent start clears err.
